// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory request port between an instruction-fetch requester (imem)
// and a load/store requester (dmem).
//
// Grant policy (combinational, decided in the request cycle):
//   - Nothing is granted while the memory is not ready.
//   - dmem normally wins.
//   - imem wins once dmem has been granted STARVE_LIMIT times in a row while
//     imem was waiting.
//   - Reads need a free tracking slot. A dmem write never needs one.
//
// Each accepted read pushes the requester ID into an in-order FIFO. Each memory
// response pops the head ID and is steered back to that requester in the same
// cycle. A response that arrives while no read is tracked is dropped. It also
// sets a sticky error flag.
//
// Ports
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_imem_ren, i_imem_addr          fetch read request
//   o_imem_ready                     fetch request accepted this cycle
//   o_imem_valid, o_imem_rdata       fetch data return
//   i_dmem_ren, i_dmem_wen           data read / write request (write wins)
//   i_dmem_addr, i_dmem_wdata        data address / write data
//   i_dmem_mask                      byte mask
//   o_dmem_ready                     data request accepted this cycle
//   o_dmem_valid, o_dmem_rdata       load data return
//   o_mem_addr/ren/wen/wdata/mask    shared memory request
//   i_mem_ready                      memory can accept a request
//   i_mem_valid, i_mem_rdata         memory read data return
//   o_outstanding                    reads in flight
//   o_err                            sticky: response with no read outstanding
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_imem_ren,
   input  logic [31:0]                i_imem_addr,
   output logic                       o_imem_ready,
   output logic                       o_imem_valid,
   output logic [31:0]                o_imem_rdata,
   input  logic                       i_dmem_ren,
   input  logic                       i_dmem_wen,
   input  logic [31:0]                i_dmem_addr,
   input  logic [31:0]                i_dmem_wdata,
   input  logic [3:0]                 i_dmem_mask,
   output logic                       o_dmem_ready,
   output logic                       o_dmem_valid,
   output logic [31:0]                o_dmem_rdata,
   output logic [31:0]                o_mem_addr,
   output logic                       o_mem_ren,
   output logic                       o_mem_wen,
   output logic [31:0]                o_mem_wdata,
   output logic [3:0]                 o_mem_mask,
   input  logic                       i_mem_ready,
   input  logic                       i_mem_valid,
   input  logic [31:0]                i_mem_rdata,
   output logic [$clog2(DEPTH):0]     o_outstanding,
   output logic                       o_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);
   localparam logic          ID_IMEM  = 1'b0;
   localparam logic          ID_DMEM  = 1'b1;

   // Saturating increment of the starve counter.
   function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] cur);
      logic [SW-1:0] nxt;
      if (cur >= STARVE_C) begin
         nxt = STARVE_C;
      end else begin
         nxt = cur + SW'(1'b1);
      end
      return nxt;
   endfunction

   // Tracking state
   logic [CW-1:0]    count_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [DEPTH-1:0] id_fifo_r;
   logic [SW-1:0]    starve_r;
   logic             err_r;

   // Decision signals
   logic dmem_is_wr_s;
   logic dmem_is_rd_s;
   logic pop_s;
   logic stray_s;
   logic room_s;
   logic imem_elig_s;
   logic dmem_elig_s;
   logic imem_force_s;
   logic gnt_imem_s;
   logic gnt_dmem_s;
   logic push_s;
   logic head_id_s;

   // Classify the dmem request and the response, then pick the winner.
   always_comb begin
      dmem_is_wr_s = i_dmem_wen;
      dmem_is_rd_s = i_dmem_ren & ~i_dmem_wen;
      head_id_s    = id_fifo_r[rd_ptr_r];
      pop_s        = i_mem_valid & (count_r != {CW{1'b0}});
      stray_s      = i_mem_valid & (count_r == {CW{1'b0}});
      // A pop in this cycle frees a slot for a read accepted in this cycle.
      room_s       = (count_r < DEPTH_C) | pop_s;
      imem_elig_s  = i_mem_ready & i_imem_ren & room_s;
      dmem_elig_s  = i_mem_ready & (dmem_is_wr_s | (dmem_is_rd_s & room_s));
      imem_force_s = (starve_r == STARVE_C) & i_imem_ren;
      if (imem_elig_s && (imem_force_s || !dmem_elig_s)) begin
         gnt_imem_s = 1'b1;
         gnt_dmem_s = 1'b0;
      end else if (dmem_elig_s) begin
         gnt_imem_s = 1'b0;
         gnt_dmem_s = 1'b1;
      end else begin
         gnt_imem_s = 1'b0;
         gnt_dmem_s = 1'b0;
      end
      push_s = gnt_imem_s | (gnt_dmem_s & dmem_is_rd_s);
   end

   // Drive the grant, memory request and response ports. Everything is forced
   // to zero while reset is held, so the ports go quiet as soon as reset rises.
   always_comb begin
      o_imem_ready = 1'b0;
      o_dmem_ready = 1'b0;
      o_mem_ren    = 1'b0;
      o_mem_wen    = 1'b0;
      o_mem_addr   = 32'h0000_0000;
      o_mem_wdata  = 32'h0000_0000;
      o_mem_mask   = 4'b0000;
      o_imem_valid = 1'b0;
      o_imem_rdata = 32'h0000_0000;
      o_dmem_valid = 1'b0;
      o_dmem_rdata = 32'h0000_0000;
      if (i_rst) begin
         o_imem_ready = 1'b0;
      end else begin
         if (gnt_imem_s) begin
            o_imem_ready = 1'b1;
            o_mem_ren    = 1'b1;
            o_mem_addr   = i_imem_addr;
            o_mem_mask   = 4'b1111;
         end else if (gnt_dmem_s) begin
            o_dmem_ready = 1'b1;
            o_mem_ren    = dmem_is_rd_s;
            o_mem_wen    = dmem_is_wr_s;
            o_mem_addr   = i_dmem_addr;
            o_mem_wdata  = i_dmem_wdata;
            o_mem_mask   = i_dmem_mask;
         end else begin
            o_mem_ren    = 1'b0;
         end
         if (pop_s) begin
            case (head_id_s)
               ID_IMEM: begin
                  o_imem_valid = 1'b1;
                  o_imem_rdata = i_mem_rdata;
               end
               ID_DMEM: begin
                  o_dmem_valid = 1'b1;
                  o_dmem_rdata = i_mem_rdata;
               end
               default: begin
                  o_imem_valid = 1'b0;
                  o_dmem_valid = 1'b0;
               end
            endcase
         end else begin
            o_imem_valid = 1'b0;
         end
      end
   end

   // In-order requester-ID FIFO and occupancy count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_r   <= {CW{1'b0}};
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         id_fifo_r <= {DEPTH{1'b0}};
      end else begin
         if (push_s) begin
            id_fifo_r[wr_ptr_r] <= gnt_dmem_s ? ID_DMEM : ID_IMEM;
            wr_ptr_r            <= wr_ptr_r + AW'(1'b1);
         end else begin
            wr_ptr_r            <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Starve counter: counts dmem wins while imem is waiting.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         starve_r <= {SW{1'b0}};
      end else if (gnt_imem_s || !i_imem_ren) begin
         starve_r <= {SW{1'b0}};
      end else if (gnt_dmem_s) begin
         starve_r <= starve_inc(starve_r);
      end else begin
         starve_r <= starve_r;
      end
   end

   // Sticky error for a response that arrives with nothing outstanding.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_r <= 1'b0;
      end else if (stray_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign o_outstanding = count_r;
   assign o_err         = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        imem_ren;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        dmem_ren;
   logic        dmem_wen;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_mask;
   logic        dmem_ready;
   logic        dmem_valid;
   logic [31:0] dmem_rdata;
   logic [31:0] mem_addr;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_mask;
   logic        mem_ready;
   logic        mem_valid;
   logic [31:0] mem_rdata;
   logic [2:0]  outstanding;
   logic        err;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.DEPTH(4), .STARVE_LIMIT(2)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_imem_ren    (imem_ren),
      .i_imem_addr   (imem_addr),
      .o_imem_ready  (imem_ready),
      .o_imem_valid  (imem_valid),
      .o_imem_rdata  (imem_rdata),
      .i_dmem_ren    (dmem_ren),
      .i_dmem_wen    (dmem_wen),
      .i_dmem_addr   (dmem_addr),
      .i_dmem_wdata  (dmem_wdata),
      .i_dmem_mask   (dmem_mask),
      .o_dmem_ready  (dmem_ready),
      .o_dmem_valid  (dmem_valid),
      .o_dmem_rdata  (dmem_rdata),
      .o_mem_addr    (mem_addr),
      .o_mem_ren     (mem_ren),
      .o_mem_wen     (mem_wen),
      .o_mem_wdata   (mem_wdata),
      .o_mem_mask    (mem_mask),
      .i_mem_ready   (mem_ready),
      .i_mem_valid   (mem_valid),
      .i_mem_rdata   (mem_rdata),
      .o_outstanding (outstanding),
      .o_err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ir;
      logic [31:0] iaddr;
      logic        dr;
      logic        dw;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [3:0]  dmask;
      logic        rdy;
      logic        mv;
      logic [31:0] rdata;
      logic        e_gi;
      logic        e_gd;
      logic        e_iv;
      logic        e_dv;
      logic [2:0]  e_out;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ir, input logic [31:0] iaddr, input logic dr, input logic dw,
                      input logic [31:0] daddr, input logic [31:0] dwdata, input logic [3:0] dmask,
                      input logic rdy, input logic mv, input logic [31:0] rdata,
                      input logic e_gi, input logic e_gd, input logic e_iv, input logic e_dv,
                      input logic [2:0] e_out, input logic e_err);
      vec_t t;
      t.ir = ir; t.iaddr = iaddr; t.dr = dr; t.dw = dw; t.daddr = daddr;
      t.dwdata = dwdata; t.dmask = dmask; t.rdy = rdy; t.mv = mv; t.rdata = rdata;
      t.e_gi = e_gi; t.e_gd = e_gd; t.e_iv = e_iv; t.e_dv = e_dv;
      t.e_out = e_out; t.e_err = e_err;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] iaddr, input logic dr, input logic dw,
                        input logic [31:0] daddr, input logic [31:0] dwdata, input logic [3:0] dmask,
                        input logic rdy, input logic mv, input logic [31:0] rdata);
      imem_ren = ir; imem_addr = iaddr; dmem_ren = dr; dmem_wen = dw;
      dmem_addr = daddr; dmem_wdata = dwdata; dmem_mask = dmask;
      mem_ready = rdy; mem_valid = mv; mem_rdata = rdata;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, " gi"},    32'(imem_ready), 32'h0);
      chk({tag, " gd"},    32'(dmem_ready), 32'h0);
      chk({tag, " ren"},   32'(mem_ren),    32'h0);
      chk({tag, " wen"},   32'(mem_wen),    32'h0);
      chk({tag, " addr"},  mem_addr,        32'h0);
      chk({tag, " mask"},  32'(mem_mask),   32'h0);
      chk({tag, " iv"},    32'(imem_valid), 32'h0);
      chk({tag, " ird"},   imem_rdata,      32'h0);
      chk({tag, " dv"},    32'(dmem_valid), 32'h0);
      chk({tag, " drd"},   dmem_rdata,      32'h0);
   endtask

   initial begin
      // Cycle trace, DEPTH=4, STARVE_LIMIT=2.
      //  ir iaddr          dr dw daddr          wdata          mask  rdy mv rdata           gi gd iv dv out err
      add(0, 32'h100, 0, 0, 32'h200, 32'h0, 4'hF, 1, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0); // idle
      add(1, 32'h100, 1, 0, 32'h200, 32'h0, 4'hF, 0, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0); // mem not ready
      add(1, 32'h100, 1, 0, 32'h200, 32'h0, 4'hF, 1, 0, 32'h0,         0, 1, 0, 0, 3'd0, 0); // D
      add(1, 32'h100, 1, 0, 32'h204, 32'h0, 4'hF, 1, 0, 32'h0,         0, 1, 0, 0, 3'd1, 0); // D
      add(1, 32'h100, 1, 0, 32'h208, 32'h0, 4'hF, 1, 0, 32'h0,         1, 0, 0, 0, 3'd2, 0); // I forced
      add(1, 32'h104, 1, 0, 32'h20C, 32'h0, 4'hF, 1, 1, 32'hAAAA0001,  0, 1, 0, 1, 3'd3, 0); // D, rsp->D
      add(1, 32'h104, 0, 0, 32'h210, 32'h0, 4'hF, 1, 1, 32'hBBBB0002,  1, 0, 0, 1, 3'd3, 0); // I, rsp->D
      add(0, 32'h108, 1, 0, 32'h214, 32'h0, 4'hF, 1, 1, 32'hCCCC0003,  0, 1, 1, 0, 3'd3, 0); // D, rsp->I
      add(1, 32'h108, 1, 0, 32'h218, 32'h0, 4'hF, 1, 0, 32'h0,         0, 1, 0, 0, 3'd3, 0); // D -> full
      add(1, 32'h108, 1, 0, 32'h21C, 32'h0, 4'hF, 1, 0, 32'h0,         0, 0, 0, 0, 3'd4, 0); // reads blocked
      add(1, 32'h108, 0, 1, 32'h300, 32'h12345678, 4'h3, 1, 0, 32'h0,  0, 1, 0, 0, 3'd4, 0); // write while full
      add(1, 32'h108, 1, 0, 32'h220, 32'h0, 4'hF, 1, 1, 32'hDDDD0004,  1, 0, 0, 1, 3'd4, 0); // pop frees slot
      add(0, 32'h10C, 1, 1, 32'h020, 32'h55AA55AA, 4'hF, 1, 0, 32'h0,  0, 1, 0, 0, 3'd4, 0); // ren+wen -> write
      add(0, 32'h0,   0, 0, 32'h0,   32'h0, 4'h0, 1, 1, 32'hEEEE0005,  0, 0, 1, 0, 3'd4, 0); // rsp->I
      add(0, 32'h0,   0, 0, 32'h0,   32'h0, 4'h0, 1, 1, 32'h11110006,  0, 0, 0, 1, 3'd3, 0); // rsp->D
      add(0, 32'h0,   0, 0, 32'h0,   32'h0, 4'h0, 1, 1, 32'h22220007,  0, 0, 0, 1, 3'd2, 0); // rsp->D
      add(0, 32'h0,   0, 0, 32'h0,   32'h0, 4'h0, 1, 1, 32'h33330008,  0, 0, 1, 0, 3'd1, 0); // rsp->I
      add(0, 32'h0,   0, 0, 32'h0,   32'h0, 4'h0, 1, 1, 32'h44440009,  0, 0, 0, 0, 3'd0, 0); // stray rsp
      add(0, 32'h0,   0, 0, 32'h0,   32'h0, 4'h0, 1, 0, 32'h0,         0, 0, 0, 0, 3'd0, 1); // err sticky

      rst = 1'b1;
      idle();
      #2;
      chk_quiet("reset");
      chk("reset out", 32'(outstanding), 32'h0);
      chk("reset err", 32'(err), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         logic        e_ren, e_wen;
         logic [31:0] e_addr, e_wdata;
         logic [3:0]  e_mask;
         string       tg;
         v = vecs[i];
         @(negedge clk);
         drive(v.ir, v.iaddr, v.dr, v.dw, v.daddr, v.dwdata, v.dmask, v.rdy, v.mv, v.rdata);
         #1;
         e_ren   = v.e_gi | (v.e_gd & ~v.dw);
         e_wen   = v.e_gd & v.dw;
         e_addr  = v.e_gi ? v.iaddr : (v.e_gd ? v.daddr : 32'h0);
         e_wdata = v.e_gd ? v.dwdata : 32'h0;
         e_mask  = v.e_gi ? 4'hF : (v.e_gd ? v.dmask : 4'h0);
         tg = $sformatf("v%0d", i);
         chk({tg, " gi"},    32'(imem_ready),  32'(v.e_gi));
         chk({tg, " gd"},    32'(dmem_ready),  32'(v.e_gd));
         chk({tg, " ren"},   32'(mem_ren),     32'(e_ren));
         chk({tg, " wen"},   32'(mem_wen),     32'(e_wen));
         chk({tg, " addr"},  mem_addr,         e_addr);
         chk({tg, " wdata"}, mem_wdata,        e_wdata);
         chk({tg, " mask"},  32'(mem_mask),    32'(e_mask));
         chk({tg, " iv"},    32'(imem_valid),  32'(v.e_iv));
         chk({tg, " ird"},   imem_rdata,       v.e_iv ? v.rdata : 32'h0);
         chk({tg, " dv"},    32'(dmem_valid),  32'(v.e_dv));
         chk({tg, " drd"},   dmem_rdata,       v.e_dv ? v.rdata : 32'h0);
         chk({tg, " out"},   32'(outstanding), 32'(v.e_out));
         chk({tg, " err"},   32'(err),         32'(v.e_err));
      end

      // Three dmem reads in flight, then an asynchronous reset mid-cycle.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h400 + 32'(k * 4), 32'h0, 4'hF, 1'b1, 1'b0, 32'h0);
      end
      @(negedge clk);
      drive(1'b1, 32'h500, 1'b1, 1'b0, 32'h404, 32'h0, 4'hF, 1'b1, 1'b1, 32'h99990001);
      #1;
      chk("pre-rst out", 32'(outstanding), 32'h3);
      chk("pre-rst dv", 32'(dmem_valid), 32'h1);
      rst = 1'b1;
      #1;
      chk_quiet("async rst");
      chk("async rst out", 32'(outstanding), 32'h0);
      chk("async rst err", 32'(err), 32'h0);
      @(negedge clk);
      idle();
      rst = 1'b0;
      #1;
      chk("post-rst out", 32'(outstanding), 32'h0);
      chk("post-rst err", 32'(err), 32'h0);

      // A late response after reset release is a stray response.
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h77770001);
      #1;
      chk("late iv", 32'(imem_valid), 32'h0);
      chk("late dv", 32'(dmem_valid), 32'h0);
      @(negedge clk);
      idle();
      #1;
      chk("late err", 32'(err), 32'h1);
      @(negedge clk);
      idle();
      #1;
      chk("late err held", 32'(err), 32'h1);
      rst = 1'b1;
      #1;
      chk("err cleared", 32'(err), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Lone fetch with a memory latency of four cycles.
      @(negedge clk);
      drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      #1;
      chk("lat gi", 32'(imem_ready), 32'h1);
      chk("lat ren", 32'(mem_ren), 32'h1);
      chk("lat addr", mem_addr, 32'h10);
      chk("lat mask", 32'(mem_mask), 32'hF);
      chk("lat out0", 32'(outstanding), 32'h0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         idle();
         #1;
         chk($sformatf("lat wait%0d out", k), 32'(outstanding), 32'h1);
         chk($sformatf("lat wait%0d iv", k), 32'(imem_valid), 32'h0);
      end
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFEF00D);
      #1;
      chk("lat iv", 32'(imem_valid), 32'h1);
      chk("lat ird", imem_rdata, 32'hCAFEF00D);
      chk("lat dv", 32'(dmem_valid), 32'h0);
      chk("lat out1", 32'(outstanding), 32'h1);
      @(negedge clk);
      idle();
      #1;
      chk("lat out end", 32'(outstanding), 32'h0);
      chk("lat err", 32'(err), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
